// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Optional hang detector enabled by defining AXIL_MASTER_TIMEOUT_EN (adds the timeout port).
module axil_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, RSP} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  resp_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic        aw_done, w_done;

  // A channel counts as done once its VALID has dropped or its handshake is happening now.
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
          if (cmd_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= RD;
          end
        end
        WR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: if (M_AXI_BVALID) begin
          resp_q      <= M_AXI_BRESP;
          rdata_q     <= '0;
          bready_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RD: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RDATA;
        end
        RDATA: if (M_AXI_RVALID) begin
          rdata_q     <= M_AXI_RDATA;
          resp_q      <= M_AXI_RRESP;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             advance, waiting;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    advance = 1'b0;
    waiting = 1'b0;
    unique case (state_q)
      IDLE:    advance = cmd_valid;
      WR:      begin waiting = 1'b1; advance = aw_done && w_done; end
      WRESP:   begin waiting = 1'b1; advance = M_AXI_BVALID;      end
      RD:      begin waiting = 1'b1; advance = M_AXI_ARREADY;     end
      RDATA:   begin waiting = 1'b1; advance = M_AXI_RVALID;      end
      RSP:     advance = rsp_ready;
      default: advance = 1'b1;
    endcase
  end

  // Counter saturates at CNT_MAX; the flag is report-only and never touches the handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (advance || !waiting)     wait_cnt_q <= '0;
      else if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (waiting && wait_cnt_q == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: table of transactions with a cycle-level slave, plus
// hand sequences for stray responses, the hang flag and reset in the middle of a write.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
`ifdef AXIL_MASTER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, ar_dly, rsp_dly;  // READY/VALID delays seen by the slave
    logic [1:0]  resp;
    logic [31:0] bus_rdata;                       // driven on RDATA throughout the vector
    int          rsp_hold;                        // cycles rsp_ready is held low
    int          exp_lat;                         // negedges from accept to rsp_valid
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0;  M_AXI_RVALID = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int aw_n = 0, w_n = 0, ar_n = 0, rs_n = 0, lat = 0;
    bit aw_fire = 0, w_fire = 0, ar_fire = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, got = 0;
    @(negedge clk);
    check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    M_AXI_RDATA = v.bus_rdata; M_AXI_RRESP = v.resp; M_AXI_BRESP = v.resp;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clk);
      cmd_valid = 0;
      aw_hs = aw_hs | aw_fire; w_hs = w_hs | w_fire; ar_hs = ar_hs | ar_fire;
      aw_fire = 0; w_fire = 0; ar_fire = 0;
      if (n == 1) begin
        check($sformatf("v%0d_busy", idx), busy, 1);
        check($sformatf("v%0d_cmd_ready_busy", idx), cmd_ready, 0);
      end
      if (rsp_valid) begin
        got = 1; lat = n; clear_slave();
      end else if (v.wr) begin
        if (!aw_hs) begin
          check($sformatf("v%0d_awvalid", idx), M_AXI_AWVALID, 1);
          check($sformatf("v%0d_awaddr", idx), M_AXI_AWADDR, v.addr);
          M_AXI_AWREADY = (aw_n == v.aw_dly); aw_fire = M_AXI_AWREADY; aw_n++;
        end else begin
          check($sformatf("v%0d_awvalid_drop", idx), M_AXI_AWVALID, 0);
          M_AXI_AWREADY = 0;
        end
        if (!w_hs) begin
          check($sformatf("v%0d_wvalid", idx), M_AXI_WVALID, 1);
          check($sformatf("v%0d_wdata", idx), M_AXI_WDATA, v.wdata);
          check($sformatf("v%0d_wstrb", idx), {28'd0, M_AXI_WSTRB}, {28'd0, v.wstrb});
          M_AXI_WREADY = (w_n == v.w_dly); w_fire = M_AXI_WREADY; w_n++;
        end else begin
          check($sformatf("v%0d_wvalid_drop", idx), M_AXI_WVALID, 0);
          M_AXI_WREADY = 0;
        end
        check($sformatf("v%0d_bready", idx), M_AXI_BREADY, aw_hs && w_hs);
        M_AXI_BVALID = (aw_hs && w_hs && rs_n == v.rsp_dly);
        if (aw_hs && w_hs) rs_n++;
      end else begin
        if (!ar_hs) begin
          check($sformatf("v%0d_arvalid", idx), M_AXI_ARVALID, 1);
          check($sformatf("v%0d_araddr", idx), M_AXI_ARADDR, v.addr);
          M_AXI_ARREADY = (ar_n == v.ar_dly); ar_fire = M_AXI_ARREADY; ar_n++;
        end else begin
          check($sformatf("v%0d_arvalid_drop", idx), M_AXI_ARVALID, 0);
          M_AXI_ARREADY = 0;
        end
        check($sformatf("v%0d_rready", idx), M_AXI_RREADY, ar_hs);
        M_AXI_RVALID = (ar_hs && rs_n == v.rsp_dly);
        if (ar_hs) rs_n++;
      end
    end
    clear_slave();
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_resp", idx), {30'd0, rsp_resp}, {30'd0, v.exp_resp});
    // Held response: payload must stay put and a stray command must not be taken.
    for (int i = 0; i < v.rsp_hold; i++) begin
      cmd_valid = (i == 0); cmd_write = 0;
      @(negedge clk);
      check($sformatf("v%0d_hold_valid", idx), rsp_valid, 1);
      check($sformatf("v%0d_hold_rdata", idx), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_hold_resp", idx), {30'd0, rsp_resp}, {30'd0, v.exp_resp});
      check($sformatf("v%0d_hold_cmd_ready", idx), cmd_ready, 0);
    end
    rsp_ready = 1; cmd_valid = 1; cmd_write = 0;
    @(negedge clk);
    rsp_ready = 0; cmd_valid = 0;
    check($sformatf("v%0d_done_valid", idx), rsp_valid, 0);
    check($sformatf("v%0d_done_cmd_ready", idx), cmd_ready, 1);
    check($sformatf("v%0d_done_busy", idx), busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{wr:1, addr:32'h10, wdata:32'hA5A5_0001, wstrb:4'hF, aw_dly:0, w_dly:0, ar_dly:0,
                rsp_dly:0, resp:2'b00, bus_rdata:32'hDEAD_BEEF, rsp_hold:0, exp_lat:3,
                exp_rdata:32'h0, exp_resp:2'b00};
    vecs[1] = '{wr:0, addr:32'h00, wdata:32'h0, wstrb:4'h0, aw_dly:0, w_dly:0, ar_dly:0,
                rsp_dly:2, resp:2'b00, bus_rdata:32'h0000_0002, rsp_hold:0, exp_lat:5,
                exp_rdata:32'h0000_0002, exp_resp:2'b00};
    vecs[2] = '{wr:1, addr:32'h20, wdata:32'h1122_3344, wstrb:4'h3, aw_dly:0, w_dly:3, ar_dly:0,
                rsp_dly:1, resp:2'b10, bus_rdata:32'h5555_AAAA, rsp_hold:0, exp_lat:7,
                exp_rdata:32'h0, exp_resp:2'b10};
    vecs[3] = '{wr:0, addr:32'h44, wdata:32'h0, wstrb:4'h0, aw_dly:0, w_dly:0, ar_dly:2,
                rsp_dly:0, resp:2'b11, bus_rdata:32'hCAFE_F00D, rsp_hold:0, exp_lat:5,
                exp_rdata:32'hCAFE_F00D, exp_resp:2'b11};
    vecs[4] = '{wr:1, addr:32'h08, wdata:32'hFFFF_0000, wstrb:4'h5, aw_dly:2, w_dly:0, ar_dly:0,
                rsp_dly:0, resp:2'b01, bus_rdata:32'h7777_7777, rsp_hold:0, exp_lat:5,
                exp_rdata:32'h0, exp_resp:2'b01};
    vecs[5] = '{wr:0, addr:32'h0FFC, wdata:32'h0, wstrb:4'h0, aw_dly:0, w_dly:0, ar_dly:1,
                rsp_dly:1, resp:2'b00, bus_rdata:32'h1234_5678, rsp_hold:5, exp_lat:5,
                exp_rdata:32'h1234_5678, exp_resp:2'b00};

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    clear_slave();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
    check("rst_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", {30'd0, rsp_resp}, 0);
    check("rst_addr", M_AXI_AWADDR | M_AXI_ARADDR, 0);
    check("rst_wdata", M_AXI_WDATA, 0);
    check("rst_wstrb", {28'd0, M_AXI_WSTRB}, 0);
    check("prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    check("rst_timeout", timeout, 0);
`endif
    rst = 0;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stray responses while idle: no capture, no state change.
    M_AXI_BVALID = 1; M_AXI_BRESP = 2'b11;
    M_AXI_RVALID = 1; M_AXI_RRESP = 2'b11; M_AXI_RDATA = 32'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk);
      check("stray_idle_busy", busy, 0);
      check("stray_idle_rsp_valid", rsp_valid, 0);
      check("stray_idle_rdata", rsp_rdata, 32'h1234_5678);
      check("stray_idle_resp", {30'd0, rsp_resp}, 0);
    end

    // Hung write: AWREADY/WREADY withheld, strays still high.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      cmd_valid = 0;
      check("hang_awvalid", M_AXI_AWVALID, 1);
      check("hang_wvalid", M_AXI_WVALID, 1);
      check("hang_bready", M_AXI_BREADY, 0);
      check("hang_rsp_valid", rsp_valid, 0);
      check("hang_rdata", rsp_rdata, 32'h1234_5678);
`ifdef AXIL_MASTER_TIMEOUT_EN
      check($sformatf("hang_timeout_c%0d", n), timeout, 0);
`endif
    end
    @(negedge clk);
    check("hang_awvalid_late", M_AXI_AWVALID, 1);
    check("hang_awaddr_late", M_AXI_AWADDR, 32'h30);
`ifdef AXIL_MASTER_TIMEOUT_EN
    check("hang_timeout_set", timeout, 1);
`endif
    M_AXI_BVALID = 0; M_AXI_RVALID = 0;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    @(negedge clk);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    check("hang_bready_after", M_AXI_BREADY, 1);
    M_AXI_BVALID = 1; M_AXI_BRESP = 2'b01;
    @(negedge clk);
    M_AXI_BVALID = 0;
    check("hang_rsp_valid_after", rsp_valid, 1);
    check("hang_rsp_resp", {30'd0, rsp_resp}, 32'd1);
    check("hang_rsp_rdata", rsp_rdata, 0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    check("hang_timeout_sticky", timeout, 1);
`endif
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("hang_done_cmd_ready", cmd_ready, 1);

    // Reset while waiting in WRESP abandons the write.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h0000_00FF; cmd_wstrb = 4'h1;
    @(negedge clk);
    cmd_valid = 0;
    check("rstmid_awvalid", M_AXI_AWVALID, 1);
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    @(negedge clk);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    check("rstmid_in_wresp", M_AXI_BREADY, 1);
    rst = 1; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
    #1;
    check("rstmid_bready", M_AXI_BREADY, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rstmid_cmd_ready", cmd_ready, 1);
    check("rstmid_no_rsp", rsp_valid, 0);
    check("rstmid_resp_cleared", {30'd0, rsp_resp}, 0);
    check("rstmid_addr_cleared", M_AXI_AWADDR, 0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    check("rstmid_timeout_cleared", timeout, 0);
`endif
    M_AXI_BVALID = 0;
    @(negedge clk);
    check("rstmid_still_idle", rsp_valid | busy, 0);

    run_vec(vecs[1], 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles waiting on any single AXI handshake before the timeout flag is set.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- busy  out  1  high in any state but IDLE.
- timeout  out  1  sticky hang flag, present only with the macro.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite master channels; widths 32/1/1, 32/4/1/1, 2/1/1, 32/1/1, 32/2/1/1.
- M_AXI_AWPROT, M_AXI_ARPROT  out  3  tied to 3'b000.

Function
REQ-003 SHALL implement the states IDLE, WR, WRESP, RD, RDATA and RSP.
REQ-004 SHALL drive cmd_ready = IDLE, combinationally; a handshake in IDLE registers addr, wdata and wstrb, then enters WR if cmd_write is 1, else RD.
REQ-005 On entering WR, SHALL assert AWVALID and WVALID together in the cycle after the cmd handshake.
REQ-006 SHALL drop AWVALID and WVALID independently on their own handshakes.
REQ-007 SHALL hold each of AWVALID, WVALID and ARVALID, and its payload, stable until its READY is seen.
REQ-008 SHALL enter WRESP in the cycle after both AW and W have completed; this covers both handshakes in one cycle and either order across cycles.
REQ-009 SHALL assert BREADY only in WRESP; on BVALID it captures BRESP into rsp_resp, sets rsp_rdata = 0 and enters RSP.
REQ-010 SHALL assert ARVALID throughout RD; on ARREADY it enters RDATA.
REQ-011 SHALL assert RREADY only in RDATA; on RVALID it captures RDATA and RRESP and enters RSP.
REQ-012 SHALL hold rsp_valid high in RSP until rsp_ready, then return to IDLE.
REQ-013 SHALL not accept a new command in the cycle rsp_ready is taken; cmd_ready next rises one cycle after the RSP exit.
REQ-014 SHALL keep exactly one transaction outstanding; no pipelining.
REQ-015 SHALL ignore stray BVALID and RVALID outside WRESP and RDATA; no capture and no state change.
REQ-016 SHALL register all AXI outputs, with no combinational path from AXI inputs to AXI outputs.

Reset
REQ-017 On rst high, SHALL immediately enter IDLE and drive all VALID/READY outputs, rsp_valid, busy and timeout to 0.
REQ-018 SHALL reset rsp_rdata, rsp_resp and the address/data registers to 0.
REQ-019 SHALL abandon any in-flight transaction on reset mid-operation, with no response generated.
REQ-020 SHALL assert cmd_ready in the first clock edge after rst deasserts.

Configuration
REQ-021 With macro AXIL_MASTER_TIMEOUT_EN defined, SHALL run a wait counter, cleared on every state change, that increments in WR, WRESP, RD and RDATA.
REQ-022 With the macro defined, SHALL set timeout sticky when the counter reaches TIMEOUT_CYCLES-1, and clear it only by rst.
REQ-023 With the macro defined, timeout SHALL be report-only: VALIDs stay asserted and AXI compliance is preserved.
REQ-024 Without the macro, SHALL omit the counter and the timeout port.

Verification
REQ-025 Write, slave ready in idle: cmd write addr 0x10 data 0xA5A5_0001 wstrb 0xF; AWREADY and WREADY high on the first VALID cycle, BVALID in the following cycle -> rsp_valid with rsp_resp 00, then IDLE.
REQ-026 Split write: WREADY 3 cycles after AWREADY -> AWVALID drops after 1 cycle, WVALID stays until its READY, BREADY rises only after both handshakes.
REQ-027 Read: addr 0x00; RVALID 2 cycles after the AR handshake, carrying 0x0000_0002 -> rsp_rdata 0x0000_0002, rsp_resp 00.
REQ-028 Backpressure: rsp_ready held low 5 cycles -> rsp_valid and data stable; a cmd_valid pulse during RSP is not accepted.
REQ-029 Reset mid-operation: rst pulsed while in WRESP -> BREADY 0 at once, no rsp_valid, cmd_ready 1 after release.
REQ-030 Macro on, TIMEOUT_CYCLES=16, AWREADY never asserted -> timeout 1 after 16 cycles in WR, AWVALID still 1.
